// File: rtl/io_pkg.sv
// ---------------------------------------------------------------------------
// io_pkg
//   Shared constants for the memory-mapped I/O controller.
//   - IO word-select codes (decoded from IOAddr[3:2])
//   - TSTAT register bit positions
//   - 7-segment anode patterns (active-low, one digit enabled at a time)
// ---------------------------------------------------------------------------
package io_pkg;

    typedef logic [1:0] io_sel_t;

    // Register select codes (IOAddr[3:2])
    localparam io_sel_t IO_DISP    = 2'b00;
    localparam io_sel_t IO_SPEED   = 2'b01;
    localparam io_sel_t IO_TPERIOD = 2'b10;
    localparam io_sel_t IO_TSTAT   = 2'b11;

    // TSTAT read-back bit positions
    localparam int TICK_BIT = 0;
    localparam int OVR_BIT  = 1;

    // Anode patterns, active-low, digit 0 is the rightmost
    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

endpackage

// File: rtl/io_tick_timer.sv
// ---------------------------------------------------------------------------
// io_tick_timer
//   Programmable tick timer polled by software through TPERIOD / TSTAT.
//   A non-zero period makes the counter run down and reload, raising
//   tick_flag once every `period` cycles; a tick that finds the flag still
//   set raises overrun. A zero period stops the timer with count at 0.
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   period_wr    in   load strobe: period and count take period_wdata
//   period_wdata in   [TIMER_W-1:0] new period
//   stat_clr     in   clear strobe for tick_flag and overrun
//   count        out  [TIMER_W-1:0] current down-counter value
//   tick_flag    out  sticky tick indication
//   overrun      out  sticky "tick while flag already set"
// ---------------------------------------------------------------------------
module io_tick_timer #(
    parameter int TIMER_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               period_wr,
    input  logic [TIMER_W-1:0] period_wdata,
    input  logic               stat_clr,
    output logic [TIMER_W-1:0] count,
    output logic               tick_flag,
    output logic               overrun
);

    localparam logic [TIMER_W-1:0] CNT_ONE = TIMER_W'(1);

    logic [TIMER_W-1:0] period_q, period_d;
    logic [TIMER_W-1:0] count_q,  count_d;
    logic               flag_q,   flag_d;
    logic               ovr_q,    ovr_d;

    always_comb begin
        period_d = period_q;
        count_d  = count_q;
        flag_d   = flag_q;
        ovr_d    = ovr_q;

        // Clear is applied first so that a tick on the same edge overrides it.
        if (stat_clr) begin
            flag_d = 1'b0;
            ovr_d  = 1'b0;
        end

        if (period_wr) begin
            // A period load beats a coincident tick: restart, no flag.
            period_d = period_wdata;
            count_d  = period_wdata;
        end else if (period_q == '0) begin
            count_d = '0;
        end else if (count_q <= CNT_ONE) begin
            // Reload at 1 (never 0) so the interval is exactly `period`.
            count_d = period_q;
            flag_d  = 1'b1;
            ovr_d   = ovr_q | flag_q;
        end else begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            period_q <= period_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            ovr_q    <= ovr_d;
        end
    end

    assign count     = count_q;
    assign tick_flag = flag_q;
    assign overrun   = ovr_q;

endmodule

// File: rtl/io_controller.sv
// ---------------------------------------------------------------------------
// io_controller
//   Memory-mapped I/O between the MIPS core IO port and the board:
//   28-bit display register with 4-digit 7-segment scan, synchronised
//   SPEED switches, and a programmable tick timer (io_tick_timer).
//   Word select is IOAddr[3:2]: 00 DISP, 01 SPEED, 10 TPERIOD, 11 TSTAT.
//
//   Optional build macro SWITCH_DEBOUNCE_EN: when defined, the synchronised
//   SPEED value must hold for DEBOUNCE_CYCLES cycles (>= 2) before it is
//   accepted; otherwise speed_q is the plain 2-FF synchroniser output.
//
// Ports
//   CLK          in   system clock (10 MHz)
//   RESET_N      in   asynchronous active-low reset
//   IOAddr       in   [3:0]  IO word address
//   IOWriteEn    in   write strobe
//   IOWriteData  in   [31:0] write data
//   IOReadData   out  [31:0] combinational read data
//   SPEED        in   [1:0]  raw switch inputs
//   LED          out  [6:0]  segments, active-low
//   AN           out  [3:0]  anodes, active-low
//   TICK_IRQ     out  copy of the tick flag
// ---------------------------------------------------------------------------
module io_controller
    import io_pkg::*;
#(
    parameter int SCAN_BITS       = 16,
    parameter int TIMER_W         = 24,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [3:0]  IOAddr,
    input  logic        IOWriteEn,
    input  logic [31:0] IOWriteData,
    output logic [31:0] IOReadData,
    input  logic [1:0]  SPEED,
    output logic [6:0]  LED,
    output logic [3:0]  AN,
    output logic        TICK_IRQ
);

    io_sel_t sel;
    logic    wr_disp, wr_tperiod, wr_tstat;

    assign sel        = IOAddr[3:2];
    assign wr_disp    = IOWriteEn && (sel == IO_DISP);
    assign wr_tperiod = IOWriteEn && (sel == IO_TPERIOD);
    assign wr_tstat   = IOWriteEn && (sel == IO_TSTAT);

    // Byte-offset bits and the unused top data nibble are don't-care.
    logic unused_bits;
    assign unused_bits = ^{IOAddr[1:0], IOWriteData[31:28]};

    logic [27:0]          disp_q, disp_d;
    logic [SCAN_BITS-1:0] scan_q, scan_d;
    logic [1:0]           sync1_q;
    logic [1:0]           speed_q;

    assign disp_d = wr_disp ? IOWriteData[27:0] : disp_q;
    assign scan_d = scan_q + 1'b1;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            disp_q  <= '0;
            scan_q  <= '0;
            sync1_q <= 2'b00;
        end else begin
            disp_q  <= disp_d;
            scan_q  <= scan_d;
            sync1_q <= SPEED;
        end
    end

`ifdef SWITCH_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync2_q;
    logic [1:0]      cand_q, cand_d;
    logic [DB_W-1:0] db_q, db_d;
    logic [1:0]      speed_d;

    // db_q counts consecutive cycles the candidate has differed from
    // speed_q; any change of the candidate restarts it at 1.
    always_comb begin
        cand_d  = cand_q;
        db_d    = db_q;
        speed_d = speed_q;
        if (sync2_q == speed_q) begin
            cand_d = sync2_q;
            db_d   = '0;
        end else if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            db_d   = DB_W'(1);
        end else if (db_q == DB_LAST) begin
            speed_d = cand_q;
            db_d    = '0;
        end else begin
            db_d = db_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync2_q <= 2'b00;
            cand_q  <= 2'b00;
            db_q    <= '0;
            speed_q <= 2'b00;
        end else begin
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            db_q    <= db_d;
            speed_q <= speed_d;
        end
    end
`else
    // Second synchroniser stage is the architectural speed value.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            speed_q <= 2'b00;
        end else begin
            speed_q <= sync1_q;
        end
    end
`endif

    logic [TIMER_W-1:0] tmr_count;
    logic               tmr_flag;
    logic               tmr_ovr;

    io_tick_timer #(
        .TIMER_W(TIMER_W)
    ) u_timer (
        .clk          (CLK),
        .rst_n        (RESET_N),
        .period_wr    (wr_tperiod),
        .period_wdata (IOWriteData[TIMER_W-1:0]),
        .stat_clr     (wr_tstat),
        .count        (tmr_count),
        .tick_flag    (tmr_flag),
        .overrun      (tmr_ovr)
    );

    assign TICK_IRQ = tmr_flag;

    always_comb begin
        IOReadData = '0;
        case (sel)
            IO_DISP:    IOReadData = {4'b0, disp_q};
            IO_SPEED:   IOReadData = {30'b0, speed_q};
            IO_TPERIOD: IOReadData = {{(32-TIMER_W){1'b0}}, tmr_count};
            default: begin
                IOReadData[TICK_BIT] = tmr_flag;
                IOReadData[OVR_BIT]  = tmr_ovr;
            end
        endcase
    end

    // Top two scan bits pick the digit; segments are raw register bits.
    always_comb begin
        AN  = AN_DIG0;
        LED = ~disp_q[6:0];
        case (scan_q[SCAN_BITS-1:SCAN_BITS-2])
            2'd0: begin AN = AN_DIG0; LED = ~disp_q[6:0];   end
            2'd1: begin AN = AN_DIG1; LED = ~disp_q[13:7];  end
            2'd2: begin AN = AN_DIG2; LED = ~disp_q[20:14]; end
            default: begin AN = AN_DIG3; LED = ~disp_q[27:21]; end
        endcase
    end

endmodule

// File: doc/io_controller.md
Name: io_controller

Overview:
- Memory-mapped I/O controller between the MIPS core's IO port (IOAddr/IOWriteEn/IOWriteData/IOReadData) and the board peripherals.
- Owns the 28-bit display register and the 4-digit 7-segment scan.
- Synchronises the 2-bit SPEED switches.
- Provides a programmable tick timer, so snake software polls a flag instead of running delay loops.
- Sits in the top level between the MIPS core and the board pins; runs on the 10 MHz divided clock.

Parameters:
- SCAN_BITS, 16, width of the display refresh counter; top 2 bits select the digit.
- TIMER_W, 24, width of the tick timer period and counter.
- DEBOUNCE_CYCLES, 100000, stable cycles required before a SPEED change is accepted; used only with SWITCH_DEBOUNCE_EN.

Ports:
- CLK, input, 1, system clock (10 MHz divided clock).
- RESET_N, input, 1, asynchronous active-low reset.
- IOAddr, input, 4, IO word address from the core.
- IOWriteEn, input, 1, write strobe, qualified on the CLK rising edge.
- IOWriteData, input, 32, write data.
- IOReadData, output, 32, combinational read data for IOAddr.
- SPEED, input, 2, raw asynchronous switch inputs.
- LED, output, 7, segment drive, active-low.
- AN, output, 4, digit anodes, active-low.
- TICK_IRQ, output, 1, copy of the tick flag, for a future interrupt line.

Behaviour:
- Interface (already decided): one clock, CLK; reset RESET_N is asynchronous and active-low.
- All state clears on RESET_N low regardless of CLK; release is not re-synchronised by this block.
- Address decode uses IOAddr[3:2]; IOAddr[1:0] is ignored.
  - 00 DISP: write loads disp_reg <= IOWriteData[27:0]; read returns {4'b0, disp_reg}.
  - 01 SPEED: read returns {30'b0, speed_q}; writes ignored.
  - 10 TPERIOD: write loads period <= IOWriteData[TIMER_W-1:0] and count <= same value; read returns the zero-extended current count.
  - 11 TSTAT: read returns {30'b0, overrun, tick_flag}; any write clears both.
- Reset values: disp_reg 0, period 0, count 0, tick_flag 0, overrun 0, speed_q 2'b00, scan counter 0, AN 4'b1110, LED 7'h7F, TICK_IRQ 0.
- SPEED path: 2-FF synchroniser into speed_q. A switch change is visible on IOReadData 2 edges later.
- Timer:
  - period == 0: timer disabled, count held at 0, no ticks.
  - Otherwise count decrements each cycle.
  - When count == 1, next edge: count <= period and tick_flag <= 1. Tick interval is exactly `period` cycles.
  - Tick while tick_flag is already 1: overrun <= 1.
  - Tick and TSTAT write on the same edge: set wins (flag stays 1, overrun unchanged by the clear).
  - TPERIOD write on the same edge as a tick: the write wins; count <= new period, no flag set.
  - Wrap-around: period = 2^TIMER_W-1 is legal; count never underflows past 1.
- Display scan:
  - Free-running SCAN_BITS counter.
  - sel = cnt[SCAN_BITS-1:SCAN_BITS-2] selects digit and anode: 0 → AN 1110, disp_reg[6:0]; 1 → 1101, [13:7]; 2 → 1011, [20:14]; 3 → 0111, [27:21].
  - LED = ~digit; segments are raw bits, no hex decode.
  - AN/LED are combinational from the counter and disp_reg; a DISP write shows on the next cycle.
- IOReadData is purely combinational. Reads have no side effects.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_EN.
- Defined: after synchronisation, a candidate value must stay constant for DEBOUNCE_CYCLES consecutive cycles before speed_q updates. Any change restarts the count. Latency is 2 + DEBOUNCE_CYCLES edges.
- Undefined: speed_q is the 2-FF synchroniser output; no debounce counter is instantiated.

Decomposition:
- Shared package io_pkg holds:
  - address constants IO_DISP=2'b00, IO_SPEED=2'b01, IO_TPERIOD=2'b10, IO_TSTAT=2'b11;
  - TSTAT bit indices TICK_BIT=0, OVR_BIT=1;
  - the anode pattern constants.
- One sub-module, io_tick_timer: period/count/tick_flag/overrun plus the load and clear strobes. Decode, synchroniser and scan stay in io_controller.

Test Plan:
- Reset mid-operation: write DISP 28'h0ABCDEF, set period 10, pulse RESET_N low between edges → immediately disp_reg=0, AN=1110, LED=7'h7F, TSTAT reads 0, no further ticks.
- DISP write 28'h1234567 → IOReadData at addr 0 = 32'h01234567; over a full scan, AN 0111 drives LED=~7'h09, and AN 1110 drives LED=~7'h67.
- SPEED changes 00→10 (no debounce) → addr 4 reads 0 for 2 edges, then 32'h2. With SWITCH_DEBOUNCE_EN and DEBOUNCE_CYCLES=8: a 5-cycle glitch is ignored; a stable change appears after 10 edges.
- TPERIOD=5 → tick_flag sets every 5 cycles. Leave it uncleared → TSTAT=3 after the second tick. Write TSTAT → reads 0 next cycle.
- TSTAT write on the same edge as a tick → TSTAT reads 1. TPERIOD=7 written on a tick edge → no flag; next tick 7 cycles later.
- TPERIOD=0 → count reads 0, no flag after 100 cycles. Writes to addr 4 leave all state unchanged.
